// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared definitions for the instruction-fetch block: FSM
//               state encoding, reset PC default, MIPS opcode constants and
//               the branch-offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

  // Fetch FSM states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  // PC loaded on reset unless the instantiation overrides it
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Default instruction-memory word-address width
  localparam int IMEM_AW_DEFAULT = 14;

  // Primary opcodes (Instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  // R-type function codes (Instruction[5:0])
  localparam logic [5:0] FN_JR    = 6'h08;

  // Sign-extend a 16-bit branch immediate and scale it to a byte offset
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage : instr_fetch_pkg

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// ============================================================================
// Module      : instr_fetch_if
// Description : Instruction-memory read bus between the fetch unit (master)
//               and the instruction memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_if #(
  parameter int IMEM_AW = 14
);

  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               imem_valid;

  // Fetch unit side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  // Instruction memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );

endinterface : instr_fetch_if

`default_nettype wire

// File: rtl/instr_fetch_npc_sel.sv
// ============================================================================
// Module      : npc_sel
// Description : Combinational next-PC selection for the fetch unit.
//               Priority: jr, then j/jal, then taken branch, then PC+4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_sel
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] target,     // Instruction[25:0]; [15:0] is the branch immediate
  input  logic        jr,
  input  logic        jmp,
  input  logic        jal,
  input  logic        branch,
  input  logic        nbranch,
  input  logic        zero,
  input  logic [29:0] jr_word,    // Read_data_1[31:2]; low bits are forced to zero
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic take_branch;

  // Sequential address wraps naturally at 2^32
  assign pc_plus4    = pc + 32'd4;
  assign take_branch = (branch & zero) | (nbranch & ~zero);

  // Priority mux: jr beats jumps, jumps beat branches
  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = {jr_word, 2'b00};
    end else if (jmp | jal) begin
      next_pc = {pc_plus4[31:28], target, 2'b00};
    end else if (take_branch) begin
      next_pc = pc_plus4 + branch_offset(target[15:0]);
    end
  end

endmodule : npc_sel

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch unit. Requests one word from instruction
//               memory, holds it for execute until acknowledged, then
//               advances the PC using the decoded control of the held
//               instruction. Flags jr targets that are not word aligned.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = IMEM_AW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset_n,

  // Decoded control and operands for the held instruction
  input  logic          Branch,
  input  logic          nBranch,
  input  logic          Jmp,
  input  logic          Jal,
  input  logic          Jr,
  input  logic          Zero,
  input  logic [31:0]   Read_data_1,
  input  logic          instr_ack,

  // Instruction-memory read bus
  instr_fetch_if.master imem,

  // Fetched instruction towards execute
  output logic [31:0]   Instruction,
  output logic          inst_valid,
  output logic [31:0]   PC,
  output logic [31:0]   link_addr,
  output logic          misalign
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  instr;
  logic         held;
  logic         req;
  logic         misalign_flag;
  logic [31:0]  next_pc;
  logic [31:0]  pc_plus4;
  logic         jr_unaligned;

  npc_sel u_npc_sel (
    .pc       (pc),
    .target   (instr[25:0]),
    .jr       (Jr),
    .jmp      (Jmp),
    .jal      (Jal),
    .branch   (Branch),
    .nbranch  (nBranch),
    .zero     (Zero),
    .jr_word  (Read_data_1[31:2]),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  assign jr_unaligned = Jr && (Read_data_1[1:0] != 2'b00);

  // Fetch FSM with registered outputs; control inputs only matter on HOLD+ack
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      instr         <= 32'h0000_0000;
      held          <= 1'b0;
      req           <= 1'b0;
      misalign_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Single settle cycle after reset; any memory response here is stale
          state <= ST_REQ;
          req   <= 1'b1;
        end
        ST_REQ: begin
          if (imem.imem_valid) begin
            instr <= imem.imem_rdata;
            held  <= 1'b1;
            req   <= 1'b0;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (instr_ack) begin
            pc    <= next_pc;
            held  <= 1'b0;
            req   <= 1'b1;
            state <= ST_REQ;
            if (jr_unaligned) begin
              misalign_flag <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          held  <= 1'b0;
          req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc[IMEM_AW+1:2];

  assign Instruction = instr;
  assign inst_valid  = held;
  assign PC          = pc;
  assign link_addr   = pc_plus4;
  assign misalign    = misalign_flag;

endmodule : instr_fetch

`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded at reset.
REQ-002 Parameter IMEM_AW, default 14, SHALL be the instruction-memory word-address width.
REQ-003 clock  input  1  SHALL be the sole clock; all state updates occur on its rising edge.
REQ-004 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 Branch, nBranch, Jmp, Jal, Jr  input  1 each  SHALL carry decoded control for the currently held instruction.
REQ-006 Zero  input  1  SHALL be the ALU equality result for the held instruction.
REQ-007 Read_data_1  input  32  SHALL be the rs register value, used as the jr target.
REQ-008 instr_ack  input  1  SHALL mean that execute has consumed the held instruction this cycle.
REQ-009 imem_req  output  1  SHALL request an instruction-memory read.
REQ-010 imem_addr  output  IMEM_AW  SHALL be the word address, equal to PC[IMEM_AW+1:2].
REQ-011 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-012 imem_valid  input  1  SHALL mark imem_rdata valid, with latency of 1 or more cycles.
REQ-013 Instruction  output  32  SHALL be the held instruction (Opcode = [31:26], Function_opcode = [5:0]).
REQ-014 inst_valid  output  1  SHALL be high while Instruction is valid and awaiting instr_ack.
REQ-015 PC  output  32  SHALL be the address of the held or requested instruction.
REQ-016 link_addr  output  32  SHALL equal PC+4 combinationally, for the jal $31 write.
REQ-017 misalign  output  1  SHALL be a sticky flag set by a jr to a target that is not word-aligned.

Function
REQ-018 The FSM SHALL have states IDLE, REQ and HOLD; reset SHALL enter IDLE.
REQ-019 IDLE SHALL last exactly one cycle, then move to REQ.
REQ-020 In REQ, imem_req SHALL be 1; on imem_valid, the block SHALL capture imem_rdata into Instruction and move to HOLD, so inst_valid rises on the cycle after imem_valid.
REQ-021 In HOLD, the block SHALL assert inst_valid and imem_req=0, and hold Instruction and PC stable until instr_ack.
REQ-022 On HOLD with instr_ack=1, the block SHALL load PC with next_pc, move to REQ, and drive inst_valid low on the following cycle.
REQ-023 next_pc SHALL be selected by priority: Jr -> {Read_data_1[31:2],2'b00}; else Jmp|Jal -> {(PC+4)[31:28], Instruction[25:0], 2'b00}; else (Branch&Zero)|(nBranch&~Zero) -> PC+4+(sign-extended Instruction[15:0] << 2); else PC+4.
REQ-024 Control inputs and Zero SHALL be sampled only in HOLD with instr_ack=1; at all other times they SHALL be ignored.
REQ-025 instr_ack outside HOLD SHALL be ignored.
REQ-026 imem_valid outside REQ SHALL be ignored, including stale responses after reset.
REQ-027 All PC arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 -> 32'h0).
REQ-028 When Jr and Jmp (or Branch) are asserted together, Jr SHALL win.
REQ-029 misalign SHALL set when a committed Jr has Read_data_1[1:0] != 0, and SHALL clear only on reset.
REQ-030 Throughput SHALL be one instruction per 3 cycles at minimum: REQ, then HOLD, then back to REQ on ack, with single-cycle memory.

Reset
REQ-031 Asserting reset_n=0 at any time, including mid-REQ, SHALL immediately force: state=IDLE, PC=RESET_PC, Instruction=0, inst_valid=0, imem_req=0, misalign=0.
REQ-032 Deassertion SHALL be synchronised externally; the first fetch SHALL address RESET_PC.

Structure
REQ-033 The FSM state encodings and the RESET_PC default SHALL be defined in the shared definitions include, alongside the existing opcode macros.
REQ-034 next_pc selection SHALL be a single combinational sub-module, npc_sel; the FSM and registers SHALL stay in instr_fetch.

Verification
REQ-035 Reset, then imem_valid 2 cycles after imem_req with rdata 32'h2008_0005 -> imem_addr=0; inst_valid=1 on the next cycle; PC=0.
REQ-036 Held instruction at PC=0x10 with Branch=1, Zero=1, imm=16'hFFFE, ack -> next imem_addr corresponds to PC=0x0C; with Zero=0 -> PC=0x14.
REQ-037 Jal at PC=0x0040_0000 with instr[25:0]=26'h10 -> link_addr=0x0040_0004; next PC=0x0000_0040.
REQ-038 Jr and Jmp both asserted, Read_data_1=0x0000_0102, ack -> PC=0x0000_0100 and misalign=1; misalign remains 1 after later acks.
REQ-039 reset_n pulsed low during REQ, then a late imem_valid arrives in IDLE -> it is ignored; the fetch restarts at RESET_PC and inst_valid stays 0 until a new response.
REQ-040 PC=0xFFFF_FFFC, no branch, ack -> PC=0x0000_0000.
